// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer with stall hold, pending redirect and branch squash; define DELAY_SLOT_EN to issue the delay-slot instruction as valid
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddr,
  output logic        IMemEn,
  input  logic [31:0] IMemDout,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);
`ifdef DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d, instr_pc_q, instr_pc_d, pend_pc_q, pend_pc_d, redir_pc;
  logic        instr_valid_q, instr_valid_d, pend_q, pend_d;
  assign redir_pc    = RedirectPC & ~32'h3;
  assign IMemAddr    = f_pc_q;
  assign IMemEn      = rst_n & ~Stall;
  assign Instruction = IMemDout;
  assign InstrPC     = instr_pc_q;
  assign PCPlus4     = instr_pc_q + 32'd4;
  assign InstrValid  = instr_valid_q;
  // Next state: stalled edges only record redirects; unstalled edges advance and squash the fall-through slot
  always_comb begin
    state_d       = state_q;
    f_pc_d        = f_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    if (Stall) begin
      state_d   = (state_q == BOOT) ? BOOT : HOLD;
      pend_d    = pend_q | Redirect;
      pend_pc_d = Redirect ? redir_pc : pend_pc_q;
    end else begin
      state_d       = RUN;
      instr_pc_d    = f_pc_q;
      f_pc_d        = Redirect ? redir_pc : pend_q ? pend_pc_q : f_pc_q + 32'd4;
      pend_d        = 1'b0;
      instr_valid_d = DELAY_SLOT | ~(Redirect | pend_q);
    end
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      f_pc_q        <= RESET_PC;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_pc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      f_pc_q        <= f_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected issued PCs
module tb_fetch_stage;
`ifdef DELAY_SLOT_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif
  localparam logic [31:0] KEY = 32'hDEAD_0000;
  logic        clk = 0, rst_n = 0, Stall = 0, Redirect = 0;
  logic [31:0] RedirectPC = 0, IMemAddr, IMemDout = 0, Instruction, InstrPC, PCPlus4;
  logic        IMemEn, InstrValid, adv = 0;
  int          pass_cnt = 0, chk_cnt = 0;
  logic [31:0] exp_q[$];
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemAddr(IMemAddr), .IMemEn(IMemEn), .IMemDout(IMemDout), .Instruction(Instruction),
    .InstrPC(InstrPC), .PCPlus4(PCPlus4), .InstrValid(InstrValid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (IMemEn) IMemDout <= IMemAddr ^ KEY;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic push_ok,
                      input logic [31:0] pc);
    Stall = st;
    Redirect = rd;
    RedirectPC = rpc;
    if (!st && push_ok) exp_q.push_back(pc);
    @(posedge clk);
    #1;
    Redirect = 0;
  endtask
  always @(posedge clk) adv = rst_n && !Stall;
  always @(negedge clk) begin
    if (adv && InstrValid) begin
      if (exp_q.size() == 0) chk("unexpected_issue", InstrPC, 32'hxxxx_xxxx);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("issued_pc", InstrPC, e);
        chk("issued_instr", Instruction, e ^ KEY);
        chk("issued_pc4", PCPlus4, e + 32'd4);
      end
    end
  end
  initial begin
    #2;
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_pc", InstrPC, 32'h0);
    chk("rst_valid", {31'b0, InstrValid}, 32'h0);
    chk("rst_en", {31'b0, IMemEn}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("boot_en", {31'b0, IMemEn}, 32'h1);
    chk("boot_valid", {31'b0, InstrValid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 32'(i * 4));
      chk("seq_addr", IMemAddr, 32'(i * 4 + 4));
      chk("seq_valid", {31'b0, InstrValid}, 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      Stall = 1;
      #1;
      chk("stall_en", {31'b0, IMemEn}, 32'h0);
      step(1, 0, 0, 0, 0);
      chk("stall_addr", IMemAddr, 32'h10);
      chk("stall_pc", InstrPC, 32'hC);
      chk("stall_instr", Instruction, 32'hC ^ KEY);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h10 + 32'(i * 4));
    chk("pre_br_pc", InstrPC, 32'h20);
    step(0, 1, 32'h103, DS, 32'h24);
    chk("br_addr", IMemAddr, 32'h100);
    chk("br_slot_pc", InstrPC, 32'h24);
    chk("br_slot_valid", {31'b0, InstrValid}, {31'b0, DS});
    step(0, 0, 0, 1, 32'h100);
    step(1, 1, 32'h40, 0, 0);
    step(1, 1, 32'h80, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pend_hold_addr", IMemAddr, 32'h104);
    step(0, 0, 0, DS, 32'h104);
    chk("pend_addr", IMemAddr, 32'h80);
    step(0, 0, 0, 1, 32'h80);
    chk("pend_next", IMemAddr, 32'h84);
    step(0, 1, 32'hFFFF_FFFC, DS, 32'h84);
    chk("wrap_a", IMemAddr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_b", IMemAddr, 32'h0);
    chk("wrap_pc4", PCPlus4, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    step(1, 1, 32'h200, 0, 0);
    step(0, 1, 32'h300, DS, 32'h4);
    chk("live_wins", IMemAddr, 32'h300);
    step(0, 0, 0, 1, 32'h300);
    chk("after_live", IMemAddr, 32'h304);
    step(1, 1, 32'h500, 0, 0);
    step(1, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("async_addr", IMemAddr, 32'h0);
    chk("async_pc", InstrPC, 32'h0);
    chk("async_valid", {31'b0, InstrValid}, 32'h0);
    chk("async_en", {31'b0, IMemEn}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 1, 32'h0);
    chk("restart_addr", IMemAddr, 32'h4);
    step(0, 0, 0, 1, 32'h4);
    chk("restart_addr2", IMemAddr, 32'h8);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
